// File: rtl/line_plotter.sv
// Bresenham line generator: walks every pixel from (x0,y0) to (x1,y1) in any octant
// and presents it on the frame-buffer write port, stalling while wr_ready is low.
module line_plotter #(
    parameter int COORD_W = 8,
    parameter int RGB_W   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [RGB_W-1:0]   color,
    input  logic               wr_ready,
    output logic [COORD_W-1:0] X_loc,
    output logic [COORD_W-1:0] Y_loc,
    output logic               WR_en,
    output logic [RGB_W-1:0]   RGB,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [COORD_W-1:0]        x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [RGB_W-1:0]          col_q, col_d, rgb_q, rgb_d;
    logic [COORD_W-1:0]        x_q, x_d, y_q, y_d;
    logic signed [COORD_W:0]   dx_q, dx_d, dy_q, dy_d;
    logic                      sxn_q, sxn_d, syn_q, syn_d;
    logic signed [COORD_W+1:0] err_q, err_d;

    logic [COORD_W-1:0]        adx, ady;
    logic signed [COORD_W:0]   dx_s, dy_s;
    logic signed [COORD_W+2:0] e2, dx_w, dy_w;
    logic signed [COORD_W+1:0] inc_x, inc_y;
    logic                      step_x, step_y, at_end;

    // Setup-time magnitudes; dy is kept negative so both error tests are plain compares.
    always_comb begin
        adx  = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
        ady  = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
        dx_s = {1'b0, adx};
        dy_s = -$signed({1'b0, ady});
    end

    always_comb begin
        e2     = {err_q, 1'b0};
        dx_w   = {{2{dx_q[COORD_W]}}, dx_q};
        dy_w   = {{2{dy_q[COORD_W]}}, dy_q};
        step_x = (e2 >= dy_w);
        step_y = (e2 <= dx_w);
        inc_x  = step_x ? {dy_q[COORD_W], dy_q} : '0;
        inc_y  = step_y ? {dx_q[COORD_W], dx_q} : '0;
        at_end = (x_q == x1_q) && (y_q == y1_q);
    end

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        col_d   = col_q;
        rgb_d   = rgb_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sxn_d   = sxn_q;
        syn_d   = syn_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                    col_d   = color;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                dx_d    = dx_s;
                dy_d    = dy_s;
                sxn_d   = !(x0_q < x1_q);
                syn_d   = !(y0_q < y1_q);
                err_d   = {dx_s[COORD_W], dx_s} + {dy_s[COORD_W], dy_s};
                x_d     = x0_q;
                y_d     = y0_q;
                rgb_d   = col_q;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                // Nothing advances until the frame buffer takes the current pixel.
                if (wr_ready) begin
                    if (at_end) begin
                        state_d = S_DONE;
                    end else begin
                        if (step_x) x_d = sxn_q ? (x_q - 1'b1) : (x_q + 1'b1);
                        if (step_y) y_d = syn_q ? (y_q - 1'b1) : (y_q + 1'b1);
                        err_d = err_q + inc_x + inc_y;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            col_q   <= '0;
            rgb_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            sxn_q   <= 1'b0;
            syn_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            col_q   <= col_d;
            rgb_q   <= rgb_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            sxn_q   <= sxn_d;
            syn_q   <= syn_d;
            err_q   <= err_d;
        end
    end

    assign X_loc = x_q;
    assign Y_loc = y_q;
    assign RGB   = rgb_q;
    assign WR_en = (state_q == S_DRAW);
    assign done  = (state_q == S_DONE);
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_line_plotter.sv
// Bench for line_plotter: a pixel-list model predicts every presented pixel and the
// handshake timing of each line; directed and random lines are driven through it.
module tb_line_plotter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        wr_ready = 1'b1;
    logic [7:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [11:0] color = '0;
    logic [7:0]  X_loc, Y_loc;
    logic        WR_en, busy, done;
    logic [11:0] RGB;

    line_plotter #(.COORD_W(8), .RGB_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
        .wr_ready(wr_ready),
        .X_loc(X_loc), .Y_loc(Y_loc), .WR_en(WR_en), .RGB(RGB),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference pixel list for a segment, in plain integer arithmetic.
    int bx_q[$];
    int by_q[$];
    function automatic void bres(input int ax, input int ay, input int ex, input int ey);
        int dx, dy, sx, sy, err, e2, x, y;
        bx_q.delete();
        by_q.delete();
        dx  = (ex > ax) ? ex - ax : ax - ex;
        dy  = -((ey > ay) ? ey - ay : ay - ey);
        sx  = (ax < ex) ? 1 : -1;
        sy  = (ay < ey) ? 1 : -1;
        err = dx + dy;
        x   = ax;
        y   = ay;
        for (int i = 0; i < 1024; i++) begin
            bx_q.push_back(x);
            by_q.push_back(y);
            if (x == ex && y == ey) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    // Cycle-level expectations: idle, one setup cycle, draw until list drained, one done cycle.
    typedef enum {M_IDLE, M_SETUP, M_DRAW, M_DONE} mph_t;
    mph_t ph = M_IDLE;
    int qx[$];
    int qy[$];
    int qc = 0;
    int acc_cyc = 0, done_cyc = 0, n_acc = 0, pres_cnt = 0, lines_done = 0;

    always @(negedge clk) begin
        chk("wr_done_exclusive", int'(WR_en && done), 0);
        if (!rst_n) begin
            chk("rst_X", X_loc, 0);
            chk("rst_Y", Y_loc, 0);
            chk("rst_RGB", RGB, 0);
            chk("rst_WR_en", WR_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            ph = M_IDLE;
            qx.delete();
            qy.delete();
        end else begin
            case (ph)
                M_IDLE: begin
                    chk("idle_busy", busy, 0);
                    chk("idle_WR_en", WR_en, 0);
                    chk("idle_done", done, 0);
                    if (start) begin
                        bres(x0, y0, x1, y1);
                        qx = bx_q;
                        qy = by_q;
                        qc = color;
                        n_acc = 0;
                        pres_cnt = 0;
                        ph = M_SETUP;
                    end
                end
                M_SETUP: begin
                    chk("setup_busy", busy, 1);
                    chk("setup_WR_en", WR_en, 0);
                    chk("setup_done", done, 0);
                    acc_cyc = cyc;
                    ph = M_DRAW;
                end
                M_DRAW: begin
                    chk("draw_WR_en", WR_en, 1);
                    chk("draw_busy", busy, 1);
                    chk("draw_done", done, 0);
                    chk("pix_X", X_loc, qx[0]);
                    chk("pix_Y", Y_loc, qy[0]);
                    chk("pix_RGB", RGB, qc);
                    pres_cnt++;
                    if (wr_ready) begin
                        void'(qx.pop_front());
                        void'(qy.pop_front());
                        n_acc++;
                        if (qx.size() == 0) ph = M_DONE;
                    end
                end
                default: begin
                    chk("done_pulse", done, 1);
                    chk("done_WR_en", WR_en, 0);
                    chk("done_busy", busy, 1);
                    done_cyc = cyc;
                    lines_done++;
                    ph = M_IDLE;
                end
            endcase
        end
    end

    // wr_ready driver: 0 = always ready, 1 = random, 2 = three-cycle stall at pixel 40.
    int rdy_mode = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: wr_ready = 1'b1;
                1: wr_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (!stalled && WR_en && X_loc == 8'd40) begin
                        stalled = 1'b1;
                        stall_left = 3;
                    end
                    if (stall_left > 0) begin
                        wr_ready = 1'b0;
                        stall_left--;
                    end else begin
                        wr_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic pulse_start(input int a, input int b, input int c, input int d, input int col);
        @(posedge clk);
        #1;
        x0 = 8'(a); y0 = 8'(b); x1 = 8'(c); y1 = 8'(d); color = 12'(col);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_line(input int a, input int b, input int c, input int d,
                            input int col, input bit poke);
        int ld, adx, ady;
        ld = lines_done;
        pulse_start(a, b, c, d, col);
        if (poke) begin
            // Raised during setup: must be ignored, not queued.
            x0 = 8'($urandom); y0 = 8'($urandom); x1 = 8'($urandom); y1 = 8'($urandom);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        for (int i = 0; i < 3000 && lines_done == ld; i++) @(posedge clk);
        chk("line_completes", lines_done - ld, 1);
        adx = (a > c) ? a - c : c - a;
        ady = (b > d) ? b - d : d - b;
        chk("pix_count", n_acc, ((adx > ady) ? adx : ady) + 1);
    endtask

    int steep_x[6] = '{0, 0, 1, 1, 2, 2};
    int steep_y[6] = '{0, 1, 2, 3, 4, 5};

    initial begin
        int ld;
        // Hand-computed pins on the reference model itself.
        bres(0, 0, 2, 5);
        chk("model_steep_len", bx_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("model_steep_x", bx_q[i], steep_x[i]);
            chk("model_steep_y", by_q[i], steep_y[i]);
        end
        bres(10, 5, 3, 5);
        chk("model_horiz_len", bx_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("model_horiz_x", bx_q[i], 10 - i);
            chk("model_horiz_y", by_q[i], 5);
        end
        bres(255, 255, 0, 0);
        chk("model_ext_len", bx_q.size(), 256);
        chk("model_ext_last", bx_q[255] + by_q[255], 0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_X", X_loc, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_line(0, 0, 120, 120, 12'h0F0, 1'b0);
        chk("diag_done_latency", done_cyc - acc_cyc, 122);
        chk("diag_presented", pres_cnt, 121);

        run_line(10, 5, 3, 5, 12'hABC, 1'b0);
        run_line(0, 0, 2, 5, 12'h123, 1'b0);

        rdy_mode = 2;
        stalled = 1'b0;
        run_line(0, 0, 120, 120, 12'h0F0, 1'b0);
        chk("stall_done_latency", done_cyc - acc_cyc, 125);
        chk("stall_presented", pres_cnt, 124);
        rdy_mode = 0;

        run_line(7, 7, 7, 7, 12'hFFF, 1'b0);
        chk("point_done_latency", done_cyc - acc_cyc, 2);
        run_line(255, 255, 0, 0, 12'h555, 1'b0);

        rdy_mode = 1;
        run_line(0, 255, 255, 0, 12'h00F, 1'b1);
        for (int n = 0; n < 20; n++)
            run_line($urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 4095), n[0]);
        for (int n = 0; n < 10; n++)
            run_line($urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 4095), 1'b1);

        // Abandon a line mid-flight with an asynchronous reset.
        rdy_mode = 0;
        ld = lines_done;
        pulse_start(0, 0, 120, 120, 12'h0F0);
        for (int i = 0; i < 400 && !(WR_en && X_loc == 8'd50); i++) begin
            @(posedge clk);
            #1;
        end
        chk("reached_pixel_50", X_loc, 50);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_X", X_loc, 0);
        chk("async_Y", Y_loc, 0);
        chk("async_RGB", RGB, 0);
        chk("async_WR_en", WR_en, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("no_done_after_abort", lines_done - ld, 0);
        repeat (2) @(posedge clk);
        run_line(200, 30, 40, 90, 12'h7E1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/line_plotter.md
# line_plotter

Parametrised Bresenham line generator that writes every pixel of an arbitrary line segment into the LCD frame-buffer write port. It replaces the fixed free-running diagonal test pattern. It accepts two endpoints and a colour via a start pulse, handles all eight octants, honours frame-buffer back-pressure, and signals completion. It sits between the drawing controller and the frame-buffer writer, driving the same X_loc/Y_loc/WR_en/RGB port set.

## Interface
- COORD_W, 8, width of each coordinate (unsigned screen location)
- RGB_W, 12, pixel colour width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request pulse; sampled only in IDLE
- x0, y0  in  COORD_W  start point, latched on accepted start
- x1, y1  in  COORD_W  end point, latched on accepted start
- color  in  RGB_W  line colour, latched on accepted start
- wr_ready  in  1  frame buffer accepts the presented pixel this cycle
- X_loc, Y_loc  out  COORD_W  current pixel location (registered)
- WR_en  out  1  pixel valid
- RGB  out  RGB_W  pixel colour (registered)
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE -> SETUP -> DRAW -> DONE -> IDLE.
- IDLE: when start=1, latch x0,y0,x1,y1,color, then go to SETUP. start is ignored in every other state, with no queueing.
- SETUP (1 cycle):
  - dx = |x1-x0|, dy = -|y1-y0|; both signed, COORD_W+1 bits.
  - sx = +1 if x0<x1 else -1; sy = +1 if y0<y1 else -1.
  - err = dx+dy, signed, COORD_W+2 bits.
  - X_loc=x0, Y_loc=y0, RGB=color.
- DRAW: WR_en=1. A pixel is transferred on any cycle with WR_en=1 and wr_ready=1.
  - On transfer, if X_loc==x1 and Y_loc==y1, go to DONE.
  - Otherwise compute e2 = 2*err (COORD_W+3 bits), both tests using the pre-update err:
    - if e2>=dy: err+=dy, X_loc+=sx
    - if e2<=dx: err+=dx, Y_loc+=sy
    - When both tests pass, err gets dx+dy added in the same cycle.
  - With wr_ready=0: X_loc, Y_loc, RGB and err hold and WR_en stays 1. No pixel is dropped or duplicated.
- DONE (1 cycle): done=1, WR_en=0, then go to IDLE.
- Pixel count per line = max(|x1-x0|, |y1-y0|) + 1. Coordinates never leave the closed range between the endpoints, so no wrap-around occurs.
- Degenerate input (x0=x1 and y0=y1) produces exactly one pixel.
- Reset (any state, asynchronous):
  - State returns to IDLE.
  - X_loc=0, Y_loc=0, RGB=0, WR_en=0, busy=0, done=0, internal err/dx/dy=0.
  - A line in progress is abandoned with no done pulse.

## Timing
- Reset values of all outputs are 0.
- start seen in IDLE at edge k:
  - SETUP during cycle k+1.
  - First WR_en=1 at cycle k+2.
- With wr_ready tied high, N pixels occupy cycles k+2..k+N+1, done=1 at cycle k+N+2, and IDLE at k+N+3.
- The earliest next start is accepted in cycle k+N+3.
- busy=1 from cycle k+1 through k+N+2 inclusive.
- Each wr_ready=0 cycle during DRAW adds exactly one cycle to the line.
- WR_en and done are decoded from state; done and WR_en are never high together.

## Test plan
- Diagonal (0,0)->(120,120), color=0x0F0, wr_ready=1 -> 121 writes on consecutive cycles with X_loc=Y_loc=0..120 and RGB=0x0F0; done pulses 123 cycles after start.
- Horizontal, reverse direction, (10,5)->(3,5) -> 8 writes with X_loc=10,9,...,3 and Y_loc=5; then done.
- Steep (0,0)->(2,5) -> exact sequence (0,0),(0,1),(1,2),(1,3),(2,4),(2,5); then done.
- Back-pressure on (0,0)->(120,120): wr_ready=0 for 3 cycles at pixel 40 -> (40,40) held for 4 cycles; 121 unique accepted pixels; done 3 cycles later than with no stalls.
- Single point and extremes:
  - (7,7)->(7,7) -> exactly 1 write, then done.
  - (255,255)->(0,0) -> 256 writes descending, ending at (0,0), with no wrap.
- Reset mid-line: assert rst_n=0 at pixel 50 -> all outputs 0 immediately (asynchronous), no done pulse. After release, a start with new endpoints draws correctly. A start pulsed while busy is ignored.
